// File: rtl/nor_gate_bist_ctrl_pkg.sv
// Shared types and helpers for the NOR-cell BIST sequencer.
// Vector index k maps onto the cell inputs as {a,b}.
package nor_bist_pkg;

    localparam int NUM_VEC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    function automatic logic nor_expected(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nor_gate_bist_ctrl_hold_timer.sv
// Counts clocks of one vector's hold window; tc is high in the last cycle of the window.
// clr has priority over en and forces the count back to zero.
module bist_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("bist_hold_timer: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tc    = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nor_gate_bist_ctrl.sv
// BIST sequencer for one cmos_nor_gate: walks {a,b} through 00,01,10,11, each held
// HOLD_CYCLES clocks, samples f at the end of each window and accumulates failures.
module nor_gate_bist_ctrl
    import nor_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    bist_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        dut_a_q, dut_a_d;
    logic        dut_b_q, dut_b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  err_q, err_d;
    logic [3:0]  fv_q, fv_d;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_tc;

    // Start is only honoured outside RUN; it also restarts the hold window.
    assign tmr_clr = start && (state_q != ST_RUN);
    assign tmr_en  = (state_q == ST_RUN);

    bist_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dut_a_d = dut_a_q;
        dut_b_d = dut_b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = 2'd0;
                    dut_a_d = 1'b0;
                    dut_b_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 3'd0;
                    fv_d    = 4'd0;
                end
            end
            ST_RUN: begin
                if (tmr_tc) begin
                    // Judge the vector currently on the pins, before advancing.
                    if (dut_f != nor_expected(dut_a_q, dut_b_q)) begin
                        fv_d[idx_q] = 1'b1;
                        err_d       = err_q + 3'd1;
                    end
                    if (idx_q == 2'(NUM_VEC - 1)) begin
                        state_d = ST_DONE;
                        idx_d   = 2'd0;
                        dut_a_d = 1'b0;
                        dut_b_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        idx_d              = idx_q + 2'd1;
                        {dut_a_d, dut_b_d} = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                dut_a_d = 1'b0;
                dut_b_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                err_d   = 3'd0;
                fv_d    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fv_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dut_a_q <= dut_a_d;
            dut_b_q <= dut_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fv_q;

endmodule

// File: doc/nor_gate_bist_ctrl.md
Name: nor_gate_bist_ctrl

Overview:
- Built-in self-test sequencer for the cmos_nor_gate cell.
- On a start pulse it drives the cell's a/b inputs through all four input vectors, in order 00, 01, 10, 11.
- Each vector is held for a programmable number of cycles. The cell output f is sampled at the end of each hold window and compared against the expected NOR.
- Reports per-vector failures, an error count and a pass flag. Sits between a test/config master and one cmos_nor_gate instance.

Parameters:
- HOLD_CYCLES, 4, clocks each vector is driven before f is sampled; must be >= 1, elaboration error otherwise.
- NUM_VEC, 4, number of input vectors (2^2); fixed; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to run the sequence; level also accepted, see Behaviour
- dut_a  output  1  drives cell input a
- dut_b  output  1  drives cell input b
- dut_f  input  1  cell output f, same clock domain, no synchroniser
- busy  output  1  high while the sequence is running
- done  output  1  level; high in DONE state until the next start or rst
- pass  output  1  high only while done=1 and err_count=0
- err_count  output  3  number of failing vectors, 0..4
- fail_vec  output  4  bit k set if vector k failed (k = {a,b} as a 2-bit index)

Behaviour:
- Reset: rst high forces, asynchronously, state=IDLE, dut_a=dut_b=0, busy=done=pass=0, err_count=0, fail_vec=0, hold counter=0, vector index=0.
- Reset mid-operation behaves identically: the run is abandoned and no partial results are kept.
- States: IDLE, RUN, DONE.
- IDLE:
  - dut_a/dut_b=0.
  - start=1 at edge E0 -> RUN, vector index=0, hold counter=0, err_count and fail_vec cleared, busy=1.
- RUN:
  - {dut_a,dut_b} = vector index (00, 01, 10, 11), registered outputs.
  - Vector k is driven from edge E0+k*H to edge E0+(k+1)*H, where H=HOLD_CYCLES.
  - Hold counter increments each clock. At the edge where counter = H-1:
    - dut_f is compared to expected = ~(dut_a | dut_b).
    - On mismatch, fail_vec[k] is set and err_count is incremented.
    - The counter returns to 0 and the index advances.
  - Sampling uses the currently driven vector, not the next one.
  - After vector 3 is sampled (edge E0+4H) -> DONE: busy=0, done=1, pass=(err_count_next==0), dut_a=dut_b=0.
- Latency: done is first observed high after edge E0+4*H (16 clocks with default H).
- start while busy=1 is ignored. No restart, no queuing.
- DONE:
  - Results held stable.
  - start=1 -> RUN at the same edge: results cleared, done=0, pass=0, vector 0 driven. This is identical to a start from IDLE.
  - A level-held start therefore reruns back-to-back continuously.
- err_count saturation cannot occur: maximum 4 fits in 3 bits.
- Simultaneous rst and start: rst wins.

Decomposition:
- Package nor_bist_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparam NUM_VEC=4
  - function nor_expected(a,b)
- One natural sub-module, bist_hold_timer: parameterised HOLD_CYCLES counter with clear and a terminal-count pulse output.
- The controller instantiates bist_hold_timer and holds the FSM, vector index and result registers.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; hold rst for 3 cycles, release -> outputs remain 0 and state IDLE with no start.
2. Good cell (real cmos_nor_gate connected), H=4, one-cycle start:
   - dut_a/dut_b = 00, 01, 10, 11, each for exactly 4 clocks.
   - busy high for 16 clocks; done=1 after edge E0+16.
   - pass=1, err_count=0, fail_vec=4'b0000.
3. Stuck-at-0 model (dut_f tied 0) -> only vector 00 fails: fail_vec=4'b0001, err_count=1, pass=0, done=1.
4. NAND model substituted (f=~(a&b)) -> vectors 01 and 10 fail: fail_vec=4'b0110, err_count=2, pass=0.
5. Start handling:
   - Pulse start again during RUN at vector 2 -> ignored; done still at E0+16.
   - Then pulse start in DONE -> results cleared, rerun completes with the same result after another 16 clocks.
6. rst during vector 2 of a run with the stuck-at-0 model -> immediate return to all-zero outputs. A subsequent start with the good cell gives pass=1, fail_vec=0, confirming no stale failure bits.
7. Parameter H=1 -> each vector held 1 clock, done after E0+4. With the NAND model: fail_vec=4'b0110.
